evt_packet_arbiter: RTL and testbench

//  Packet-atomic round-robin arbiter merging N_SRC event-word streams (streamers, host port) into the single

---
 rtl/sne_evt_stream_pkg.sv | 24 ++
 rtl/evt_rr_arbiter.sv | 44 ++++
 rtl/evt_packet_arbiter.sv | 176 +++++++++++++++++
 tb/tb_evt_packet_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sne_evt_stream_pkg.sv
// ----------------------------------------------------------------------------
// sne_evt_stream_pkg
// Shared definitions for the event-word stream fabric: packet header layout,
// arbiter state encoding and a small index helper.
// ----------------------------------------------------------------------------
package sne_evt_stream_pkg;

    // Header word carries the payload length (number of words after the header).
    localparam int unsigned HDR_LEN_LSB = 0;
    localparam int unsigned HDR_LEN_W   = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        ERROR   = 2'd3
    } arb_state_e;

    // idx + 1, wrapping n-1 -> 0 (n need not be a power of two).
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/evt_rr_arbiter.sv
// ----------------------------------------------------------------------------
// evt_rr_arbiter
// Combinational round-robin pick: first asserted valid at or after ptr_i,
// wrapping N-1 -> 0.
// Ports:
//   valid_i  [N]      request vector
//   ptr_i    [IDX_W]  highest-priority index this round
//   grant_o  [N]      one-hot winner, 0 when nothing is valid
//   idx_o    [IDX_W]  winner index, 0 when nothing is valid
//   any_o             at least one request is valid
// ----------------------------------------------------------------------------
module evt_rr_arbiter
    import sne_evt_stream_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    // NOTE: every signal driven here gets a default before the loop, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = ptr_i;
        for (int i = 0; i < int'(N); i++) begin
            if (!any_o && valid_i[cand]) begin
                grant_o[cand] = 1'b1;
                idx_o         = cand;
                any_o         = 1'b1;
            end
            cand = IDX_W'(wrap_inc(32'(cand), N));
        end
    end

endmodule

// File: rtl/evt_packet_arbiter.sv
// ----------------------------------------------------------------------------
// evt_packet_arbiter
// Packet-atomic round-robin merge of N_SRC event-word streams into one stream.
// A grant is held for a whole packet (header + LEN payload words). A stall
// watchdog parks the arbiter in ERROR when the owner stops mid-packet.
// Ports:
//   bus_clk_i, bus_rst_ni  clock, async active-low reset
//   enable_i               allow new grants (an in-flight packet always completes)
//   ack_error_i            leave ERROR (sampled in ERROR only)
//   src_valid_i/src_evt_i  per-source stream in, source k at [k*DATA_W +: DATA_W]
//   src_ready_o            per-source ready (only the owner sees dst_ready_i)
//   dst_valid_o/dst_evt_o  merged stream out, dst_ready_i from router
//   grant_o                one-hot owner, 0 when none
//   busy_o                 in HEADER or PAYLOAD
//   pkt_done_o             pulse on the last-beat handshake of a packet
//   error_o, error_src_o   in ERROR; owner index that timed out (held)
// ----------------------------------------------------------------------------
module evt_packet_arbiter
    import sne_evt_stream_pkg::*;
#(
    parameter int unsigned N_SRC   = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                       bus_clk_i,
    input  logic                       bus_rst_ni,
    input  logic                       enable_i,
    input  logic                       ack_error_i,
    input  logic [N_SRC-1:0]           src_valid_i,
    input  logic [N_SRC*DATA_W-1:0]    src_evt_i,
    output logic [N_SRC-1:0]           src_ready_o,
    output logic                       dst_valid_o,
    output logic [DATA_W-1:0]          dst_evt_o,
    input  logic                       dst_ready_i,
    output logic [N_SRC-1:0]           grant_o,
    output logic                       busy_o,
    output logic                       pkt_done_o,
    output logic                       error_o,
    output logic [$clog2(N_SRC)-1:0]   error_src_o
);

    localparam int unsigned IDX_W   = $clog2(N_SRC);
    localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit          WDOG_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_e             state_q, state_d;
    logic [N_SRC-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [HDR_LEN_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
    logic [IDX_W-1:0]       error_src_q, error_src_d;

    logic [N_SRC-1:0]       pick_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;

    evt_rr_arbiter #(
        .N     (N_SRC),
        .IDX_W (IDX_W)
    ) u_rr (
        .valid_i (src_valid_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Owner datapath
    logic                   active;
    logic                   cur_valid;
    logic [DATA_W-1:0]      cur_evt;
    logic [HDR_LEN_W-1:0]   hdr_len;
    logic                   beat;
    logic                   last_beat;
    logic                   stalled;
    logic                   timeout_hit;
    logic [IDX_W-1:0]       next_ptr;

    assign active    = (state_q == HEADER) || (state_q == PAYLOAD);
    assign cur_valid = src_valid_i[grant_idx_q];
    assign cur_evt   = src_evt_i[grant_idx_q*DATA_W +: DATA_W];
    assign hdr_len   = cur_evt[HDR_LEN_LSB +: HDR_LEN_W];
    assign beat      = active && cur_valid && dst_ready_i;
    assign last_beat = beat && (((state_q == HEADER) && (hdr_len == '0)) ||
                                ((state_q == PAYLOAD) && (remaining_q == HDR_LEN_W'(1))));
    // Only a missing source word counts as a stall; router backpressure does not.
    assign stalled     = active && !cur_valid;
    assign timeout_hit = WDOG_EN && stalled && (stall_cnt_q == STALL_LAST);
    assign next_ptr    = IDX_W'(wrap_inc(32'(grant_idx_q), N_SRC));

    assign src_ready_o = (active && dst_ready_i) ? grant_q : '0;
    assign dst_valid_o = active && cur_valid;
    assign dst_evt_o   = active ? cur_evt : '0;
    assign grant_o     = grant_q;
    assign busy_o      = active;
    assign pkt_done_o  = last_beat;
    assign error_o     = (state_q == ERROR);
    assign error_src_o = error_src_q;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        remaining_d = remaining_q;
        stall_cnt_d = '0;
        error_src_d = error_src_q;

        case (state_q)
            IDLE: begin
                if (enable_i && pick_any) begin
                    grant_d     = pick_grant;
                    grant_idx_d = pick_idx;
                    state_d     = HEADER;
                end
            end
            HEADER, PAYLOAD: begin
                if (timeout_hit) begin
                    state_d     = ERROR;
                    error_src_d = grant_idx_q;
                    grant_d     = '0;
                    remaining_d = '0;
                end else if (stalled) begin
                    stall_cnt_d = WDOG_EN ? stall_cnt_q + CNT_W'(1) : '0;
                end else if (last_beat) begin
                    state_d     = IDLE;
                    grant_d     = '0;
                    rr_ptr_d    = next_ptr;
                    remaining_d = '0;
                end else if (beat) begin
                    if (state_q == HEADER) begin
                        remaining_d = hdr_len;
                        state_d     = PAYLOAD;
                    end else begin
                        remaining_d = remaining_q - HDR_LEN_W'(1);
                    end
                end
            end
            ERROR: begin
                if (ack_error_i) begin
                    state_d  = IDLE;
                    rr_ptr_d = IDX_W'(wrap_inc(32'(error_src_q), N_SRC));
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge bus_clk_i or negedge bus_rst_ni) begin
        if (!bus_rst_ni) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
            remaining_q <= '0;
            stall_cnt_q <= '0;
            error_src_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            remaining_q <= remaining_d;
            stall_cnt_q <= stall_cnt_d;
            error_src_q <= error_src_d;
        end
    end

endmodule

// File: tb/tb_evt_packet_arbiter.sv
// ----------------------------------------------------------------------------
// tb_evt_packet_arbiter
// Directed bench: per-source word queues feed the DUT; a packet-level model
// predicts owner, forwarded word, readies, done pulse and error every cycle.
// ----------------------------------------------------------------------------
module tb_evt_packet_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic           ack_error = 1'b0;
    logic           dst_ready = 1'b0;
    logic [N-1:0]   src_valid = '0;
    logic [N*W-1:0] src_evt = '0;
    logic [N-1:0]   src_ready;
    logic           dst_valid;
    logic [W-1:0]   dst_evt;
    logic [N-1:0]   grant;
    logic           busy;
    logic           pkt_done;
    logic           err;
    logic [1:0]     err_src;

    always #5 clk = ~clk;

    evt_packet_arbiter #(.N_SRC(N), .DATA_W(W), .TIMEOUT(TO)) dut (
        .bus_clk_i   (clk),
        .bus_rst_ni  (rst_n),
        .enable_i    (enable),
        .ack_error_i (ack_error),
        .src_valid_i (src_valid),
        .src_evt_i   (src_evt),
        .src_ready_o (src_ready),
        .dst_valid_o (dst_valid),
        .dst_evt_o   (dst_evt),
        .dst_ready_i (dst_ready),
        .grant_o     (grant),
        .busy_o      (busy),
        .pkt_done_o  (pkt_done),
        .error_o     (err),
        .error_src_o (err_src)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_q(input string name, input int got[$], input int exp[$]);
        check({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check($sformatf("%s_%0d", name, i), (i < got.size()) ? got[i] : -1, exp[i]);
    endtask

    // Source side: each source presents the head of its word queue.
    logic [W-1:0] wq [N][$];
    bit           pause [N];
    int           popped [N];
    bit           nx_enable, nx_ack, nx_dst_ready;

    initial forever begin
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            src_valid[k]       = (wq[k].size() > 0) && !pause[k];
            src_evt[k*W +: W]  = (wq[k].size() > 0) ? wq[k][0] : '0;
        end
        enable    = nx_enable;
        ack_error = nx_ack;
        dst_ready = nx_dst_ready;
    end

    // Packet-level model.
    typedef enum int {M_IDLE, M_PKT, M_ERR} mphase_e;
    mphase_e m_ph;
    int      m_owner, m_ptr, m_left, m_stall, m_err_src;
    bit      m_first;

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int i = 0; i < N; i++)
            if (v[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    // Observation logs.
    int           cyc = 0;
    bit           chk_en = 1'b0;
    int           glog[$];
    int           rx[$];
    int           done_cyc[$];
    int           done_cnt, busy_cnt, err_cyc, stall_cyc, src2_rdy_cyc;
    bit           err_seen;
    logic [N-1:0] prev_grant;

    task automatic clear_logs();
        glog.delete(); rx.delete(); done_cyc.delete();
        done_cnt = 0; busy_cnt = 0; err_seen = 0;
        err_cyc = -1; stall_cyc = -1; src2_rdy_cyc = -1;
        for (int k = 0; k < N; k++) popped[k] = 0;
    endtask

    task automatic compare_cycle();
        logic [N-1:0] eg, erdy;
        logic         edv, edone, beat;
        logic [W-1:0] eevt;
        int           p;
        eg = '0; erdy = '0; edv = 1'b0; edone = 1'b0; beat = 1'b0; eevt = '0;
        if (m_ph == M_PKT) begin
            eg[m_owner] = 1'b1;
            edv   = src_valid[m_owner];
            eevt  = src_evt[m_owner*W +: W];
            erdy  = dst_ready ? eg : '0;
            beat  = edv && dst_ready;
            edone = beat && (m_first ? (eevt[15:0] == 16'd0) : (m_left == 1));
        end
        check("grant_o",     grant,     eg);
        check("src_ready_o", src_ready, erdy);
        check("dst_valid_o", dst_valid, edv);
        check("dst_evt_o",   dst_evt,   eevt);
        check("busy_o",      busy,      m_ph == M_PKT);
        check("pkt_done_o",  pkt_done,  edone);
        check("error_o",     err,       m_ph == M_ERR);
        check("error_src_o", err_src,   m_err_src);

        if (grant != '0 && prev_grant == '0)
            for (int k = 0; k < N; k++) if (grant[k]) glog.push_back(k);
        prev_grant = grant;
        if (dst_valid && dst_ready) rx.push_back(int'(dst_evt));
        if (pkt_done) begin done_cnt++; done_cyc.push_back(cyc); end
        if (busy) busy_cnt++;
        if (err && !err_seen) begin err_seen = 1; err_cyc = cyc; end
        if (m_ph == M_PKT && !src_valid[m_owner] && stall_cyc < 0) stall_cyc = cyc;
        if (src_ready[2] && src2_rdy_cyc < 0) src2_rdy_cyc = cyc;
        for (int k = 0; k < N; k++)
            if (src_valid[k] && src_ready[k]) begin
                void'(wq[k].pop_front());
                popped[k]++;
            end

        case (m_ph)
            M_IDLE: begin
                p = pick(src_valid, m_ptr);
                if (enable && p >= 0) begin
                    m_owner = p; m_first = 1; m_stall = 0; m_ph = M_PKT;
                end
            end
            M_PKT: begin
                if (beat) begin
                    m_stall = 0;
                    if (edone) begin
                        m_ph = M_IDLE; m_ptr = (m_owner + 1) % N;
                    end else if (m_first) begin
                        m_left = int'(eevt[15:0]); m_first = 0;
                    end else begin
                        m_left--;
                    end
                end else if (!src_valid[m_owner]) begin
                    m_stall++;
                    if (m_stall == TO) begin m_ph = M_ERR; m_err_src = m_owner; end
                end else begin
                    m_stall = 0;
                end
            end
            default: begin
                if (ack_error) begin m_ph = M_IDLE; m_ptr = (m_err_src + 1) % N; end
            end
        endcase
    endtask

    initial forever begin
        @(negedge clk);
        cyc++;
        if (chk_en) compare_cycle();
    end

    function automatic bit all_empty();
        for (int k = 0; k < N; k++) if (wq[k].size() != 0) return 0;
        return 1;
    endfunction

    task automatic apply_reset();
        @(posedge clk);
        chk_en = 0;
        for (int k = 0; k < N; k++) begin wq[k].delete(); pause[k] = 0; end
        nx_enable = 0; nx_ack = 0; nx_dst_ready = 0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_grant",     grant,     '0);
        check("rst_src_ready", src_ready, '0);
        check("rst_dst_valid", dst_valid, 0);
        check("rst_dst_evt",   dst_evt,   '0);
        check("rst_busy",      busy,      0);
        check("rst_pkt_done",  pkt_done,  0);
        check("rst_error",     err,       0);
        check("rst_error_src", err_src,   '0);
        rst_n = 1'b1;
        @(posedge clk);
        m_ph = M_IDLE; m_ptr = 0; m_err_src = 0; m_stall = 0; m_first = 0; m_left = 0;
        prev_grant = '0;
        chk_en = 1;
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int n = 0;
        do begin @(posedge clk); n++; end
        while (!(all_empty() && m_ph == M_IDLE) && n < max_cyc);
        check({name, "_timeout"}, n >= max_cyc, 0);
        repeat (2) @(posedge clk);
    endtask

    function automatic logic [W-1:0] hdr(input logic [15:0] tag, input logic [15:0] len);
        return {tag, len};
    endfunction

    initial begin
        int exp[$];
        int n;
        for (int k = 0; k < N; k++) begin pause[k] = 0; popped[k] = 0; end
        clear_logs();
        apply_reset();

        // T1: single source 1, len 3
        clear_logs();
        nx_enable = 1; nx_dst_ready = 1;
        wq[1] = '{hdr(16'hA100, 16'd3), 32'hA1000001, 32'hA1000002, 32'hA1000003};
        wait_idle(50, "t1");
        exp = '{1};                                       check_q("t1_grants", glog, exp);
        exp = '{32'hA1000003, 32'hA1000001, 32'hA1000002, 32'hA1000003};
        exp[0] = int'(hdr(16'hA100, 16'd3));              check_q("t1_words", rx, exp);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_busy_cycles", busy_cnt, 4);

        // T2: all sources, len 1 each, round-robin from pointer 0
        apply_reset();
        clear_logs();
        nx_enable = 1; nx_dst_ready = 1;
        wq[0] = '{hdr(16'hB000, 16'd1), 32'hB0000001, hdr(16'hB010, 16'd1), 32'hB0100001};
        wq[1] = '{hdr(16'hB100, 16'd1), 32'hB1000001};
        wq[2] = '{hdr(16'hB200, 16'd1), 32'hB2000001};
        wq[3] = '{hdr(16'hB300, 16'd1), 32'hB3000001};
        wait_idle(100, "t2");
        exp = '{0, 1, 2, 3, 0};                           check_q("t2_grants", glog, exp);
        check("t2_done_cnt", done_cnt, 5);
        check("t2_busy_cycles", busy_cnt, 10);
        for (int i = 1; i < done_cyc.size(); i++)
            check($sformatf("t2_spacing_%0d", i), done_cyc[i] - done_cyc[i-1], 3);

        // T3: source 2 requests during source 0's packet
        clear_logs();
        wq[0] = '{hdr(16'hC000, 16'd4), 32'hC0000001, 32'hC0000002, 32'hC0000003, 32'hC0000004};
        n = 0;
        while (popped[0] < 2 && n < 30) begin @(posedge clk); n++; end
        check("t3_start_timeout", n >= 30, 0);
        wq[2] = '{hdr(16'hC200, 16'd0)};
        wait_idle(50, "t3");
        exp = '{0, 2};                                    check_q("t3_grants", glog, exp);
        check("t3_src2_ready_after_done",
              src2_rdy_cyc - ((done_cyc.size() > 0) ? done_cyc[0] : -100), 2);

        // T4: 50% dst backpressure on a len 8 packet; enable drops mid-packet
        clear_logs();
        wq[3] = '{hdr(16'hD300, 16'd8), 32'hD3000001, 32'hD3000002, 32'hD3000003,
                  32'hD3000004, 32'hD3000005, 32'hD3000006, 32'hD3000007, 32'hD3000008};
        n = 0;
        do begin
            @(posedge clk); n++;
            nx_dst_ready = ~nx_dst_ready;
            if (popped[3] == 1) nx_enable = 0;
        end while (!(all_empty() && m_ph == M_IDLE) && n < 100);
        check("t4_timeout", n >= 100, 0);
        nx_enable = 1; nx_dst_ready = 1;
        repeat (2) @(posedge clk);
        exp = '{0, 32'hD3000001, 32'hD3000002, 32'hD3000003, 32'hD3000004,
                32'hD3000005, 32'hD3000006, 32'hD3000007, 32'hD3000008};
        exp[0] = int'(hdr(16'hD300, 16'd8));              check_q("t4_words", rx, exp);
        check("t4_done_cnt", done_cnt, 1);
        check("t4_no_error", err_seen, 0);

        // T5: source 1 stops after two payload beats -> watchdog ERROR
        clear_logs();
        wq[1] = '{hdr(16'hE100, 16'd5), 32'hE1000001, 32'hE1000002, 32'hE1000003,
                  32'hE1000004, 32'hE1000005};
        n = 0;
        while (popped[1] < 3 && n < 30) begin @(posedge clk); n++; end
        check("t5_start_timeout", n >= 30, 0);
        pause[1] = 1;
        n = 0;
        while (m_ph != M_ERR && n < 100) begin @(posedge clk); n++; end
        check("t5_error_timeout", n >= 100, 0);
        repeat (3) @(posedge clk);
        check("t5_error_latency", err_cyc - stall_cyc, 16);
        check("t5_error_held", err, 1);
        check("t5_error_src", err_src, 1);
        check("t5_beats_before_stall", popped[1], 3);
        wq[1].delete(); pause[1] = 0;
        wq[0] = '{hdr(16'hE000, 16'd0)};
        wq[2] = '{hdr(16'hE200, 16'd0)};
        glog.delete();
        nx_ack = 1;
        @(posedge clk);
        nx_ack = 0;
        wait_idle(50, "t5");
        exp = '{2, 0};                                    check_q("t5_grants", glog, exp);

        // T6: enable low holds off grants; len 0 packets are single beats
        clear_logs();
        nx_enable = 0;
        wq[0] = '{hdr(16'hF000, 16'd0)};
        wq[3] = '{hdr(16'hF300, 16'd0)};
        repeat (10) @(posedge clk);
        check("t6_no_grant", glog.size(), 0);
        check("t6_no_busy", busy_cnt, 0);
        nx_enable = 1;
        wait_idle(50, "t6");
        exp = '{3, 0};                                    check_q("t6_grants", glog, exp);
        check("t6_done_cnt", done_cnt, 2);
        check("t6_busy_cycles", busy_cnt, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
